// File: rtl/relu2_pkg.sv
// Shared types and defaults for the second ReLU stage frame sequencer.
package relu2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } relu2_state_t;

    localparam int RELU2_FRAME_LEN = 93;

endpackage : relu2_pkg

// File: rtl/relu2_lane.sv
// Single-lane signed ReLU; the neg flag reports that the lane was clipped to zero.
module relu2_lane #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             neg
);

    // clip negative codes (including the most-negative one) to zero
    always_comb begin
        neg = din[WIDTH-1];
        if (neg) begin
            dout = '0;
        end else begin
            dout = din;
        end
    end

endmodule : relu2_lane

// File: rtl/relu2_frame_ctrl.sv
// Frame sequencer for ReLU stage 2: per-lane ReLU, one-deep output register,
// frame indexing with first/last marks. Optional clip counter: RELU2_CLIPCNT_EN.
module relu2_frame_ctrl
    import relu2_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 8,
    parameter int FRAME_LEN = RELU2_FRAME_LEN,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_first,
    output logic                   out_last,
    output logic [CNT_W-1:0]       sample_idx,
    output logic                   busy,
    output logic                   frame_done
`ifdef RELU2_CLIPCNT_EN
    ,
    output logic [$clog2(LANES*FRAME_LEN+1)-1:0] clip_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    relu2_state_t           state_r;
    relu2_state_t           state_s;
    logic [CNT_W-1:0]       in_cnt_r;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   last_in_s;
    logic                   out_hs_s;
    logic                   drain_done_s;
    logic                   busy_r;
    logic                   frame_done_r;
    logic                   out_valid_r;
    logic [LANES*WIDTH-1:0] out_data_r;
    logic                   out_first_r;
    logic                   out_last_r;
    logic [CNT_W-1:0]       sample_idx_r;
    logic [LANES*WIDTH-1:0] relu_s;
`ifdef RELU2_CLIPCNT_EN
    logic [LANES-1:0]       neg_s;
`else
    logic [LANES-1:0]       neg_unused_s;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        relu2_lane #(.WIDTH(WIDTH)) u_lane (
            .din  (in_data[g*WIDTH +: WIDTH]),
            .dout (relu_s[g*WIDTH +: WIDTH]),
`ifdef RELU2_CLIPCNT_EN
            .neg  (neg_s[g])
`else
            .neg  (neg_unused_s[g])
`endif
        );
    end

    assign accept_s     = in_valid && in_ready_s;
    assign last_in_s    = (in_cnt_r == LAST_IDX);
    assign out_hs_s     = out_valid_r && out_ready;
    assign drain_done_s = (state_r == DRAIN) && out_hs_s && out_last_r;

    // next-state logic and upstream ready
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                in_ready_s = !out_valid_r || out_ready;
                if (in_valid && in_ready_s && last_in_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s    = IDLE;
                in_ready_s = 1'b0;
            end
        endcase
    end

    // state register with registered busy and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != IDLE);
            frame_done_r <= drain_done_s;
        end
    end

    // sample index counter; saturates on the last sample until the next start
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt_r <= '0;
        end else if ((state_r == IDLE) && start) begin
            in_cnt_r <= '0;
        end else if (accept_s && !last_in_s) begin
            in_cnt_r <= in_cnt_r + CNT_W'(1);
        end else begin
            in_cnt_r <= in_cnt_r;
        end
    end

    // output pipeline register; payload holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_first_r  <= 1'b0;
            out_last_r   <= 1'b0;
            sample_idx_r <= '0;
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= relu_s;
            out_first_r  <= (in_cnt_r == '0);
            out_last_r   <= last_in_s;
            sample_idx_r <= in_cnt_r;
        end else if (out_hs_s) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

`ifdef RELU2_CLIPCNT_EN
    localparam int CLIP_W = $clog2(LANES*FRAME_LEN+1);

    logic [CLIP_W-1:0] neg_cnt_s;
    logic [CLIP_W-1:0] clip_cnt_r;

    // number of clipped lanes in the current input sample
    always_comb begin
        neg_cnt_s = '0;
        for (int i = 0; i < LANES; i++) begin
            neg_cnt_s = neg_cnt_s + CLIP_W'(neg_s[i]);
        end
    end

    // per-frame clipped-lane total, kept after completion until the next start
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt_r <= '0;
        end else if ((state_r == IDLE) && start) begin
            clip_cnt_r <= '0;
        end else if (accept_s) begin
            clip_cnt_r <= clip_cnt_r + neg_cnt_s;
        end else begin
            clip_cnt_r <= clip_cnt_r;
        end
    end

    assign clip_cnt = clip_cnt_r;
`endif

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_first  = out_first_r;
    assign out_last   = out_last_r;
    assign sample_idx = sample_idx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule : relu2_frame_ctrl

// File: tb/tb_relu2_frame_ctrl.sv
// Self-checking bench for relu2_frame_ctrl: directed frame scenarios with
// randomized data/handshakes against a behavioural reference model.
module tb_relu2_frame_ctrl;

    localparam int FL = 93;
    localparam int L  = 8;
    localparam int W  = 8;
    localparam int DW = L * W;
    localparam int CW = $clog2(FL);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_first;
    logic          out_last;
    logic [CW-1:0] sample_idx;
    logic          busy;
    logic          frame_done;
`ifdef RELU2_CLIPCNT_EN
    logic [$clog2(L*FL+1)-1:0] clip_cnt;
`endif

    always #5 clk = ~clk;

    relu2_frame_ctrl #(.WIDTH(W), .LANES(L), .FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_first  (out_first),
        .out_last   (out_last),
        .sample_idx (sample_idx),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef RELU2_CLIPCNT_EN
        ,
        .clip_cnt   (clip_cnt)
`endif
    );

    // reference model: 0 idle, 1 running, 2 draining
    int            m_state = 0;
    int            m_cnt   = 0;
    bit            m_ov    = 1'b0;
    logic [DW-1:0] m_data  = '0;
    bit            m_first = 1'b0;
    bit            m_last  = 1'b0;
    int            m_idx   = 0;
    bit            m_done  = 1'b0;
    int            m_clip  = 0;

    logic [DW-1:0] q_data[$];
    int            q_idx[$];
    int            pops;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] pat_exp;
    logic [DW-1:0] bnd_in;
    logic [DW-1:0] bnd_exp;
    bit            frame1;
    bit            frame2;
    bit            poke40;
    bit            poke_drain;
    bit            use_pokes;

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < L; k++) begin
            v = $signed(d[k*W +: W]);
            if (v > 0) r[k*W +: W] = d[k*W +: W];
        end
        return r;
    endfunction

    function automatic int neg_count(input logic [DW-1:0] d);
        int n;
        int v;
        n = 0;
        for (int k = 0; k < L; k++) begin
            v = $signed(d[k*W +: W]);
            if (v < 0) n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: check ready, score handshakes, advance model, check outputs
    task automatic tick();
        logic exp_rdy;
        logic acc;
        logic hs;
        logic [DW-1:0] ed;
        int ei;
        #1;
        exp_rdy = (m_state == 1) && (!m_ov || out_ready);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = in_valid && exp_rdy;
        hs  = m_ov && out_ready;
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", 64'(q_data.size() > 0), 64'd1);
            if (q_data.size() > 0) begin
                ed = q_data.pop_front();
                ei = q_idx.pop_front();
                check("sb_data", out_data, ed);
                check("sb_idx", 64'(sample_idx), 64'(ei));
                pops++;
            end
        end
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_cnt = 0; m_ov = 1'b0; m_data = '0; m_first = 1'b0;
            m_last = 1'b0; m_idx = 0; m_done = 1'b0; m_clip = 0;
            q_data.delete();
            q_idx.delete();
        end else begin
            m_done = (m_state == 2) && hs && m_last;
            if (acc) begin
                m_data  = relu_ref(in_data);
                m_idx   = m_cnt;
                m_first = (m_cnt == 0);
                m_last  = (m_cnt == FL - 1);
                m_ov    = 1'b1;
                m_clip += neg_count(in_data);
                q_data.push_back(m_data);
                q_idx.push_back(m_cnt);
            end else if (hs) begin
                m_ov = 1'b0;
            end
            case (m_state)
                0: if (start) begin m_state = 1; m_cnt = 0; m_clip = 0; end
                1: if (acc) begin
                       if (m_cnt == FL - 1) m_state = 2;
                       else m_cnt++;
                   end
                2: if (hs && m_last) m_state = 0;
                default: m_state = 0;
            endcase
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("out_data", out_data, m_data);
        check("out_first", 64'(out_first), 64'(m_first));
        check("out_last", 64'(out_last), 64'(m_last));
        check("sample_idx", 64'(sample_idx), 64'(m_idx));
        check("busy", 64'(busy), 64'(m_state != 0));
        check("frame_done", 64'(frame_done), 64'(m_done));
`ifdef RELU2_CLIPCNT_EN
        check("clip_cnt", 64'(clip_cnt), 64'(m_clip));
`endif
        if (frame1 && m_ov) check("pattern_out", out_data, pat_exp);
        if (frame2 && m_ov && m_idx == 0) check("boundary_out", out_data, bnd_exp);
    endtask

    // drive samples until frame_done; bp: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_frame(input int bp, input int dmode, input int budget);
        int c;
        bit done;
        c = 0;
        done = 1'b0;
        pops = 0;
        while (!done && c < budget) begin
            start = 1'b0;
            if (use_pokes && m_state == 1 && m_cnt == 40 && !poke40) begin
                start = 1'b1; poke40 = 1'b1;
            end
            if (use_pokes && m_state == 2 && !poke_drain) begin
                start = 1'b1; poke_drain = 1'b1;
            end
            case (bp)
                0: out_ready = 1'b1;
                1: out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (dmode == 0) begin
                in_valid = 1'b1;
                for (int k = 0; k < L; k++) in_data[k*W +: W] = 8'(k - 4);
            end else begin
                in_valid = ($urandom_range(0, 4) != 0);
                in_data  = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) begin
                    in_data[7:0]  = 8'h80;
                    in_data[15:8] = 8'h7F;
                end
                if (frame2 && m_state == 1 && m_cnt == 0) in_data = bnd_in;
            end
            tick();
            if (m_done) done = 1'b1;
            c++;
        end
        check("frame_complete", 64'(done), 64'd1);
        check("frame_beats", 64'(pops), 64'(FL));
    endtask

    initial begin
        int c;
        pat_exp    = 64'h0302_0100_0000_0000;
        bnd_in     = {4{8'h7F, 8'h80}};
        bnd_exp    = {4{8'h7F, 8'h00}};
        frame1     = 1'b0;
        frame2     = 1'b0;
        poke40     = 1'b0;
        poke_drain = 1'b0;
        use_pokes  = 1'b0;
        pops       = 0;

        // reset held three cycles with in_valid asserted
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = '1;
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // frame 1: fixed pattern, no backpressure
        start = 1'b1;
        tick();
        frame1 = 1'b1;
        run_frame(0, 0, 400);
        frame1 = 1'b0;
`ifdef RELU2_CLIPCNT_EN
        check("clip_372", 64'(clip_cnt), 64'd372);
`endif
        start = 1'b0; in_valid = 1'b0;
        repeat (2) tick();

        // frame 2: 1,0,0,1 backpressure, random data, ignored starts
        start = 1'b1;
        tick();
        frame2 = 1'b1;
        use_pokes = 1'b1;
        run_frame(1, 1, 1500);
        frame2 = 1'b0;
        use_pokes = 1'b0;
        check("poke40_done", 64'(poke40), 64'd1);
        check("poke_drain_done", 64'(poke_drain), 64'd1);

        // start in the frame_done cycle launches frame 3
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        c = 0;
        while (!(m_ov && m_idx == 50) && c < 300) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            tick();
            c++;
        end
        check("reach_idx50", 64'(sample_idx), 64'd50);

        // mid-frame reset with a stalled output
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        repeat (3) tick();
        check("rst_no_done", 64'(frame_done), 64'd0);

        // frame 4: fully random handshakes after reset
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        run_frame(2, 1, 1500);
        start = 1'b0; in_valid = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_relu2_frame_ctrl

// File: doc/relu2_frame_ctrl.md
# relu2_frame_ctrl

Frame sequencer for the second ReLU stage of the 1-D CNN ECG classifier. It accepts one 8-lane sample per handshake from the conv-layer-2 output and applies ReLU to every lane. It registers the result toward the pooling stage with valid/ready flow control. It also counts samples per ECG frame and marks the first and last sample of each frame, arming on `start` and reporting completion with `frame_done`.

## Interface
- `WIDTH`, default 8: bits per lane, signed two's complement.
- `LANES`, default 8: channels per sample.
- `FRAME_LEN`, default 93: samples per frame. Legal range is 2 or more.
- `CNT_W`, default `$clog2(FRAME_LEN)`: sample-index width. Derived, never overridden.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. **Synchronous, active-high.** One clock domain.
- `start`, input, 1: arm one frame. Honoured only in IDLE.
- `in_valid`, input, 1: upstream sample valid.
- `in_ready`, output, 1: block accepts the sample this cycle.
- `in_data`, input, `LANES*WIDTH`: lane k occupies `[k*WIDTH +: WIDTH]`, signed.
- `out_valid`, output, 1: output register holds a sample.
- `out_ready`, input, 1: downstream accepts.
- `out_data`, output, `LANES*WIDTH`: ReLU'd lanes, same packing, non-negative.
- `out_first`, output, 1: `out_data` is sample 0 of the frame.
- `out_last`, output, 1: `out_data` is sample `FRAME_LEN-1`.
- `sample_idx`, output, `CNT_W`: frame index of `out_data`.
- `busy`, output, 1: high in RUN and DRAIN.
- `frame_done`, output, 1: one-cycle pulse when the last sample leaves.

## Operation
- **ReLU per lane.** A negative lane (MSB set) becomes 0; any other lane passes unchanged. The most-negative code also becomes 0. There is no rounding and no width change.
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE.**
  - `in_ready` is 0 and `busy` is 0.
  - `start` causes the transition to RUN next cycle and clears `in_cnt` to 0.
  - `in_valid` is ignored in IDLE.
- **RUN.**
  - `in_ready = !out_valid || out_ready`, giving a single-stage pipeline register.
  - Accept happens when `in_valid && in_ready`. On accept, the output register loads the ReLU'd data, `sample_idx` loads `in_cnt`, `out_first` loads `(in_cnt==0)`, and `out_last` loads `(in_cnt==FRAME_LEN-1)`. `in_cnt` then increments.
  - An accept with `in_cnt==FRAME_LEN-1` moves the FSM to DRAIN.
- **DRAIN.**
  - `in_ready` is 0.
  - When the `out_last` beat handshakes (`out_valid && out_ready`), the FSM returns to IDLE and `frame_done` pulses in the following cycle.
- **Output register behaviour.**
  - `out_valid` clears on a handshake unless a new accept occurs in the same cycle.
  - `out_data`, `out_first`, `out_last` and `sample_idx` hold stable while `out_valid && !out_ready`.
- **Ignored and concurrent events.**
  - `start` in RUN or DRAIN is ignored and does not restart counting.
  - `start` in the same cycle as the `frame_done` pulse (state already IDLE) is honoured.

## Timing
- **Reset values:** state IDLE, `in_cnt` 0, `in_ready` 0, `out_valid` 0, `out_data` 0, `out_first` 0, `out_last` 0, `sample_idx` 0, `busy` 0, `frame_done` 0.
- **Reset priority.** `rst` asserted mid-frame discards the held output and returns to IDLE on the next edge. No `frame_done` is produced.
- **Start.** With `start` in cycle t, `busy` and `in_ready` are 1 from cycle t+1.
- **Latency.** An input accepted at edge t appears on `out_*` in cycle t+1. This is 1-cycle latency.
- **Throughput.** One sample per cycle with `out_ready` held high.
- **Frame completion.** If the last beat handshakes at edge t, `frame_done` is 1 in cycle t+1 and `busy` is 0 from cycle t+1.
- **Counter wrap.** `in_cnt` never exceeds `FRAME_LEN-1`, and it is cleared only by `start` in IDLE or by `rst`.

## Configuration
- **`RELU2_CLIPCNT_EN` defined:**
  - Adds output `clip_cnt`, width `$clog2(LANES*FRAME_LEN+1)`.
  - On each accept, `clip_cnt` adds the number of negative lanes in that sample.
  - It is cleared by `rst` and by an honoured `start`, and holds its value after `frame_done` until the next start.
- **`RELU2_CLIPCNT_EN` not defined:** the port and counter are absent, and all other behaviour is identical.

## Structure
- **Package `relu2_pkg`:** holds the `relu2_state_t` enum (IDLE, RUN, DRAIN) and the `RELU2_FRAME_LEN` default constant.
- **Sub-module `relu2_lane`:** one per lane, instantiated via generate. It is combinational, with `WIDTH` in, `WIDTH` out, and a 1-bit `neg` flag that feeds the clip popcount.
- **Top level:** FSM, counter, output register and optional clip counter.

## Test plan
- **Reset/idle:** hold `rst` 3 cycles with `in_valid=1` → all outputs 0, no accept. After reset, `in_ready=0` until `start`.
- **Full frame, no backpressure:**
  - Stimulus: `start`, then 93 samples with lane k = k-4 (−4..3), `out_ready=1`.
  - Each output has lanes 0..3 = 0 and lanes 4..7 = 0,1,2,3.
  - `out_first` is on idx 0 and `out_last` on idx 92.
  - `frame_done` arrives 1 cycle after the last handshake.
  - With the macro defined, `clip_cnt` = 4×93 = 372.
- **Backpressure:** toggle `out_ready` 1,0,0,1 in a repeating cycle → `in_ready` follows the rule, `out_data` holds while stalled, no sample is lost or duplicated, and the idx sequence is 0..92.
- **Boundary values:** lanes of `0x80` and `0x7F` → output `0x00` and `0x7F`.
- **Ignored start:** `start` pulsed in RUN at idx 40 and again in DRAIN → no counter clear. `start` in the `frame_done` cycle → second frame runs with idx restarting at 0.
- **Mid-frame reset:** `rst` at idx 50 with `out_valid=1` and `out_ready=0` → next cycle is IDLE, `out_valid=0`, and no `frame_done` pulse.
